// File: rtl/shader_sequencer.sv
// shader_sequencer: drives one render pass for a single pixel.
// A pass first walks the voxel list (fetch, load, rasterize for each entry),
// then walks palette ids 1..palette_count (fetch, load, shade for each id),
// and ends with a one-cycle done pulse.
//
// Optional feature macro: SHADER_SEQ_SKIP_EMPTY_EN
//   defined   : voxels whose id is 0 are not rasterized; the sequencer moves
//               on as if rasterizing_done had arrived
//   undefined : every voxel is rasterized
//
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   start                        begin a pass (ignored while busy)
//   pixel_index_in, voxel_count,
//   palette_count                pass parameters, latched on start
//   voxel_addr/voxel_rd          voxel list read port, voxel_data 1 cycle later
//   palette_addr/palette_rd      palette read port, palette_data 1 cycle later
//   do_rasterize, do_shade       shader commands, held until the done strobe
//   voxel_x/y/z, voxel_id,
//   palette_entry, pixel_index   shader operands
//   rasterizing_done,
//   shading_done                 shader completion strobes
//   busy, done                   pass status
module shader_sequencer #(
   parameter int unsigned INDEX_BITS   = 32,
   parameter int unsigned COORD_BITS   = 8,
   parameter int unsigned PALETTE_BITS = 8,
   parameter int unsigned PIXEL_BITS   = 8,
   parameter int unsigned COUNT_BITS   = 16
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [INDEX_BITS-1:0]                 pixel_index_in,
   input  logic [COUNT_BITS-1:0]                 voxel_count,
   input  logic [PALETTE_BITS-1:0]               palette_count,
   output logic [COUNT_BITS-1:0]                 voxel_addr,
   output logic                                  voxel_rd,
   input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  voxel_data,
   output logic [PALETTE_BITS-1:0]               palette_addr,
   output logic                                  palette_rd,
   input  logic [PIXEL_BITS-1:0]                 palette_data,
   output logic                                  do_rasterize,
   output logic                                  do_shade,
   output logic [COORD_BITS-1:0]                 voxel_x,
   output logic [COORD_BITS-1:0]                 voxel_y,
   output logic [COORD_BITS-1:0]                 voxel_z,
   output logic [PALETTE_BITS-1:0]               voxel_id,
   output logic [PIXEL_BITS-1:0]                 palette_entry,
   output logic [INDEX_BITS-1:0]                 pixel_index,
   input  logic                                  rasterizing_done,
   input  logic                                  shading_done,
   output logic                                  busy,
   output logic                                  done
);

   localparam int unsigned VOXEL_BITS = 3 * COORD_BITS + PALETTE_BITS;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      R_FETCH = 3'd1,
      R_LOAD  = 3'd2,
      R_RUN   = 3'd3,
      S_FETCH = 3'd4,
      S_LOAD  = 3'd5,
      S_RUN   = 3'd6,
      FINISH  = 3'd7
   } state_t;

   state_t                  state, state_next;
   state_t                  adv_state;
   logic [COUNT_BITS-1:0]   v, v_next, v_inc;
   logic [PALETTE_BITS-1:0] p, p_next, adv_p;
   logic [COUNT_BITS-1:0]   vcount;
   logic [PALETTE_BITS-1:0] pcount;

   // Fields of the {x,y,z,id} voxel record
   logic [COORD_BITS-1:0]   load_x, load_y, load_z;
   logic [PALETTE_BITS-1:0] load_id;

   assign load_x  = voxel_data[VOXEL_BITS-1 -: COORD_BITS];
   assign load_y  = voxel_data[PALETTE_BITS+2*COORD_BITS-1 -: COORD_BITS];
   assign load_z  = voxel_data[PALETTE_BITS+COORD_BITS-1 -: COORD_BITS];
   assign load_id = voxel_data[PALETTE_BITS-1:0];

   // State register plus pass counters and latched pass parameters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         v      <= '0;
         p      <= '0;
         vcount <= '0;
         pcount <= '0;
      end else begin
         state <= state_next;
         v     <= v_next;
         p     <= p_next;
         if (state == IDLE && start) begin
            vcount <= voxel_count;
            pcount <= palette_count;
         end
      end
   end

   // Next-state logic; v only reaches vcount and p only reaches pcount, so
   // neither counter can wrap even at the maximum list lengths
   always_comb begin
      state_next = state;
      v_next     = v;
      p_next     = p;
      v_inc      = v + COUNT_BITS'(1);
      adv_p      = p;
      if (v_inc < vcount) begin
         adv_state = R_FETCH;
      end else if (pcount != '0) begin
         adv_state = S_FETCH;
         adv_p     = PALETTE_BITS'(1);
      end else begin
         adv_state = FINISH;
      end

      unique case (state)
         IDLE: begin
            if (start) begin
               v_next = '0;
               p_next = '0;
               if (voxel_count != '0) begin
                  state_next = R_FETCH;
               end else if (palette_count != '0) begin
                  state_next = S_FETCH;
                  p_next     = PALETTE_BITS'(1);
               end else begin
                  state_next = FINISH;
               end
            end
         end
         R_FETCH: state_next = R_LOAD;
         R_LOAD: begin
`ifdef SHADER_SEQ_SKIP_EMPTY_EN
            // Empty voxel: behave as if the rasterizer finished at once
            if (load_id == '0) begin
               v_next     = v_inc;
               p_next     = adv_p;
               state_next = adv_state;
            end else begin
               state_next = R_RUN;
            end
`else
            state_next = R_RUN;
`endif
         end
         R_RUN: begin
            if (rasterizing_done) begin
               v_next     = v_inc;
               p_next     = adv_p;
               state_next = adv_state;
            end
         end
         S_FETCH: state_next = S_LOAD;
         S_LOAD:  state_next = S_RUN;
         S_RUN: begin
            if (shading_done) begin
               if (p < pcount) begin
                  p_next     = p + PALETTE_BITS'(1);
                  state_next = S_FETCH;
               end else begin
                  state_next = FINISH;
               end
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered outputs, decoded from the next state so that each strobe is
   // high exactly while the FSM sits in the matching state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         voxel_addr    <= '0;
         voxel_rd      <= 1'b0;
         palette_addr  <= '0;
         palette_rd    <= 1'b0;
         do_rasterize  <= 1'b0;
         do_shade      <= 1'b0;
         voxel_x       <= '0;
         voxel_y       <= '0;
         voxel_z       <= '0;
         voxel_id      <= '0;
         palette_entry <= '0;
         pixel_index   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         voxel_rd     <= (state_next == R_FETCH);
         palette_rd   <= (state_next == S_FETCH);
         do_rasterize <= (state_next == R_RUN);
         do_shade     <= (state_next == S_RUN);
         busy         <= (state_next != IDLE);
         done         <= (state_next == FINISH);

         if (state_next == R_FETCH) begin
            voxel_addr <= v_next;
         end

         // voxel_data answers the read issued in R_FETCH
         if (state == R_LOAD) begin
            voxel_x <= load_x;
            voxel_y <= load_y;
            voxel_z <= load_z;
         end

         // During shading voxel_id carries the palette id being shaded
         if (state_next == S_FETCH) begin
            palette_addr <= p_next;
            voxel_id     <= p_next;
         end else if (state == R_LOAD) begin
            voxel_id <= load_id;
         end

         if (state == S_LOAD) begin
            palette_entry <= palette_data;
         end

         if (state == IDLE && start) begin
            pixel_index <= pixel_index_in;
         end
      end
   end

endmodule

// File: doc/shader_sequencer.md
SHADER_SEQUENCER -- requirements
Module: shader_sequencer

Interface
REQ-001 SHALL have parameters: INDEX_BITS, default 32, pixel index width; COORD_BITS, default 8, voxel coordinate width; PALETTE_BITS, default 8, voxel id / palette address width; PIXEL_BITS, default 8, palette entry width; COUNT_BITS, default 16, voxel list length width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin one render pass for one pixel
- pixel_index_in  in  INDEX_BITS  pixel for this pass
- voxel_count  in  COUNT_BITS  number of voxel list entries
- palette_count  in  PALETTE_BITS  highest voxel id to shade
- voxel_addr  out  COUNT_BITS  voxel list read address
- voxel_rd  out  1  voxel list read strobe
- voxel_data  in  3*COORD_BITS+PALETTE_BITS  {x,y,z,id}, valid 1 cycle after voxel_rd
- palette_addr  out  PALETTE_BITS  palette read address
- palette_rd  out  1  palette read strobe
- palette_data  in  PIXEL_BITS  valid 1 cycle after palette_rd
- do_rasterize, do_shade  out  1 each  shader commands
- voxel_x, voxel_y, voxel_z  out  COORD_BITS each  shader voxel coordinates
- voxel_id  out  PALETTE_BITS  shader voxel id
- palette_entry  out  PIXEL_BITS  shader palette value
- pixel_index  out  INDEX_BITS  shader pixel index
- rasterizing_done, shading_done  in  1 each  shader completion strobes
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end

Function
REQ-003 SHALL implement states IDLE, R_FETCH, R_LOAD, R_RUN, S_FETCH, S_LOAD, S_RUN, FINISH.
REQ-004 IDLE: start=1 latches pixel_index_in, voxel_count, palette_count; voxel index v=0; goes to R_FETCH if voxel_count>0, else S_FETCH if palette_count>0, else FINISH.
REQ-005 R_FETCH: voxel_rd=1, voxel_addr=v for exactly one cycle; next R_LOAD.
REQ-006 R_LOAD: registers voxel_data into voxel_x/y/z/id; next R_RUN.
REQ-007 R_RUN: do_rasterize=1; on rasterizing_done=1, v increments; next R_FETCH if v+1<voxel_count, else S_FETCH (palette id p=1) if palette_count>0, else FINISH.
REQ-008 S_FETCH: palette_rd=1, palette_addr=p, voxel_id=p for one cycle; next S_LOAD.
REQ-009 S_LOAD: registers palette_data into palette_entry; next S_RUN.
REQ-010 S_RUN: do_shade=1; on shading_done=1, next S_FETCH with p+1 if p<palette_count, else FINISH.
REQ-011 FINISH: done=1 one cycle; next IDLE.
REQ-012 do_rasterize and do_shade SHALL never be high simultaneously and SHALL be low outside R_RUN/S_RUN.
REQ-013 Voxel_x/y/z/id, palette_entry SHALL hold value until next load; pixel_index SHALL hold for whole pass.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 start while busy SHALL be ignored; done/strobes outside their run state SHALL be ignored.
REQ-016 Per voxel, latency from R_FETCH entry to do_rasterize=1 SHALL be 2 cycles; same for palette entries.
REQ-017 v and p counters SHALL not wrap: voxel_count=2^COUNT_BITS-1 and palette_count=2^PALETTE_BITS-1 SHALL complete without overflow.

Reset
REQ-018 reset=0 SHALL asynchronously force IDLE and all outputs, counters and latched registers to 0, including mid-pass.
REQ-019 After reset release, first start SHALL be accepted on first rising edge with reset=1.

Configuration
REQ-020 Macro SHADER_SEQ_SKIP_EMPTY_EN: when defined, R_LOAD with voxel id==0 SHALL skip R_RUN and advance as if rasterizing_done were received (do_rasterize stays 0); when undefined, id-0 voxels SHALL be rasterized normally.

Verification
REQ-021 voxel_count=2 ({0,0,0,1},{2,2,2,2}), palette_count=2, palette {1:8'h11,2:8'h22}, pixel_index_in=0 -> two rasterize runs in list order, shade ids 1 then 2 with palette_entry 8'h11, 8'h22, one done pulse.
REQ-022 voxel_count=0, palette_count=0, start -> FINISH next cycle, done pulse, no do_rasterize/do_shade.
REQ-023 start asserted again mid-pass -> ignored; latched counts and pixel_index unchanged.
REQ-024 reset=0 while in R_RUN with v=1 -> busy, do_rasterize, voxel outputs 0 immediately; next start restarts at v=0.
REQ-025 With SHADER_SEQ_SKIP_EMPTY_EN, list {0,0,0,0},{1,1,1,3} -> only one do_rasterize run (id 3); without macro -> two runs.
REQ-026 Shader stalls 50 cycles before rasterizing_done -> do_rasterize and voxel outputs held stable all 50 cycles.
